multicycle_rv_core: RTL and testbench
=====================================

Name: multicycle_rv_core

Overview:
Parametrised multi-cycle successor to the single-cycle CPU datapath. Fetches instructions over a req/ack instruction-memory handshake and decodes RV32I R-type and I-type ALU instructions. Executes them through a four-state FSM and writes results back to an internal register file. Exposes the last written value and per-instruction retire/illegal strobes for observation and bench checking.

Parameters:
XLEN, 32, datapath and register width in bits; legal values are 32 or 64.
NREG, 32, number of architectural registers; a power of two, 16 or 32; register x0 is hardwired to zero.
PC_RESET, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
IMEM_ADDR  output  XLEN  fetch address, equal to the PC
IMEM_REQ  output  1  fetch request
IMEM_ACK  input  1  fetch data valid; sampled only while IMEM_REQ=1
IMEM_DATA  input  32  instruction word, valid when IMEM_ACK=1
OUT  output  XLEN  last value written to the register file
RETIRE  output  1  one-cycle pulse per completed instruction
ILLEGAL  output  1  one-cycle pulse, coincident with RETIRE, for an unsupported instruction

Behaviour:
- Reset (RST=0, async): PC=PC_RESET, state=FETCH, all registers=0, OUT=0, IMEM_REQ=0, RETIRE=0, ILLEGAL=0.
- States and transitions:
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC. Holds until IMEM_ACK=1, then latches IMEM_DATA into IR and moves to DECODE. IMEM_REQ stays high for every wait cycle. IMEM_ACK is ignored while IMEM_REQ=0.
  - DECODE: reads rs1=IR[19:15] and rs2=IR[24:20]. Decodes opcode, funct3 and funct7 to select the ALU op. Register fields >= NREG are illegal.
  - EXEC: latches the ALU result.
  - WB: writes rd=IR[11:7] unless rd=0 or the instruction is illegal. OUT updates only on a real write. RETIRE pulses. PC advances by 4, wrapping modulo 2^XLEN. Returns to FETCH.
- Best-case latency is 4 cycles per instruction (ACK in the first FETCH cycle). Each FETCH wait cycle adds one.
- R-type, opcode 0110011:
  - add and sub (funct7 0000000 / 0100000)
  - sll, slt, sltu, xor
  - srl and sra (funct7 0000000 / 0100000)
  - or, and
- I-type, opcode 0010011:
  - addi, slti, sltiu, xori, ori, andi
  - slli, srli, srai
  - The 12-bit immediate is sign-extended to XLEN.
- Shift amount is the low log2(XLEN) bits of rs2 or the immediate.
- slt/slti compare signed; sltu/sltiu compare unsigned. The result is 1 or 0, zero-extended.
- Add/sub wrap modulo 2^XLEN; there is no overflow flag.
- Illegal instruction: any other opcode, or a funct7 not listed for its funct3. It has no register write and OUT is unchanged. ILLEGAL and RETIRE pulse together and the PC still advances by 4.
- Reading x0 always returns 0. A write to x0 is discarded.
- Reset asserted mid-instruction aborts immediately with no partial write. Fetch restarts at PC_RESET after release.

Optional Feature:
Macro: MULTICYCLE_MUL_EN.
- Defined: R-type with funct7=0000001 and funct3=000 (mul) is legal. It writes the low XLEN bits of rs1*rs2, and EXEC lasts 2 cycles for that instruction only.
- Not defined: that encoding is illegal, and no multiplier hardware is present.

Decomposition:
- Shared package:
  - opcode constants OP_R=0110011 and OP_I=0010011
  - funct3 and funct7 encodings
  - ALU-op enum
  - FSM state enum {FETCH, DECODE, EXEC, WB}
- One natural sub-module: mc_regfile, with parametrised XLEN/NREG, two asynchronous read ports, one synchronous write port, an x0 guard and async active-low reset.

Test Plan:
- Reset, then an immediate ACK on every fetch, running `addi x1,x0,5` then `addi x2,x0,-3`: OUT=5 then OUT=0xFFFFFFFD, one RETIRE each, 4 cycles apart, IMEM_ADDR 0 then 4.
- With x1=5 and x2=-3: `add x3,x1,x2`, `sub x4,x1,x2`, `slt x5,x2,x1`, `sltu x6,x2,x1`, `sra x7,x2,x1`: OUT = 2, 8, 1, 0, 0xFFFFFFFF respectively.
- ACK delayed 3 cycles on a fetch: IMEM_REQ held high with a stable IMEM_ADDR for 3 extra cycles; that instruction retires at cycle 7.
- Word 0xFFFFFFFF, then `add x0,x1,x1`: ILLEGAL and RETIRE pulse together with OUT unchanged; the x0 write is discarded and a later `add x8,x0,x0` gives OUT=0.
- RST pulsed low during EXEC of `addi x9,x0,7`: x9 stays 0, OUT=0, and the next IMEM_ADDR=PC_RESET.
- With MULTICYCLE_MUL_EN defined: `mul x3,x1,x2` (5 * -3) gives OUT=0xFFFFFFF1 after a 5-cycle latency. Without the macro, the same word produces an ILLEGAL pulse.

Source files
------------

// File: rtl/multicycle_rv_core_pkg.sv
// Shared encodings, ALU-op/FSM enums and the instruction decoder for multicycle_rv_core.
// The decoder accepts mul only when MULTICYCLE_MUL_EN is defined.
package multicycle_rv_core_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_e;

    typedef struct packed {
        alu_op_e op;
        logic    use_imm;
        logic    use_rs2;
        logic    legal;
    } dec_t;

    function automatic dec_t decode_ir(input logic [31:0] ir, input logic rv64);
        dec_t       d;
        logic [6:0] f7;
        logic [6:0] sh_f7;
        d.op      = ALU_ADD;
        d.use_imm = 1'b0;
        d.use_rs2 = 1'b0;
        d.legal   = 1'b0;
        f7        = ir[31:25];
        // RV64 immediate shifts use a 6-bit shamt, so imm[5] is not part of funct7.
        sh_f7     = rv64 ? {ir[31:26], 1'b0} : ir[31:25];
        if (ir[6:0] == OP_R) begin
            d.use_rs2 = 1'b1;
            case (ir[14:12])
                F3_ADD: begin
                    if (f7 == F7_BASE) begin
                        d.op = ALU_ADD; d.legal = 1'b1;
                    end else if (f7 == F7_ALT) begin
                        d.op = ALU_SUB; d.legal = 1'b1;
                    end
`ifdef MULTICYCLE_MUL_EN
                    else if (f7 == F7_MULDIV) begin
                        d.op = ALU_MUL; d.legal = 1'b1;
                    end
`endif
                end
                F3_SLL:  begin d.op = ALU_SLL;  d.legal = (f7 == F7_BASE); end
                F3_SLT:  begin d.op = ALU_SLT;  d.legal = (f7 == F7_BASE); end
                F3_SLTU: begin d.op = ALU_SLTU; d.legal = (f7 == F7_BASE); end
                F3_XOR:  begin d.op = ALU_XOR;  d.legal = (f7 == F7_BASE); end
                F3_SR: begin
                    if (f7 == F7_BASE) begin
                        d.op = ALU_SRL; d.legal = 1'b1;
                    end else if (f7 == F7_ALT) begin
                        d.op = ALU_SRA; d.legal = 1'b1;
                    end
                end
                F3_OR:   begin d.op = ALU_OR;   d.legal = (f7 == F7_BASE); end
                default: begin d.op = ALU_AND;  d.legal = (f7 == F7_BASE); end
            endcase
        end else if (ir[6:0] == OP_I) begin
            d.use_imm = 1'b1;
            d.legal   = 1'b1;
            case (ir[14:12])
                F3_ADD:  d.op = ALU_ADD;
                F3_SLL:  begin d.op = ALU_SLL; d.legal = (sh_f7 == F7_BASE); end
                F3_SLT:  d.op = ALU_SLT;
                F3_SLTU: d.op = ALU_SLTU;
                F3_XOR:  d.op = ALU_XOR;
                F3_SR: begin
                    if (sh_f7 == F7_BASE) begin
                        d.op = ALU_SRL;
                    end else if (sh_f7 == F7_ALT) begin
                        d.op = ALU_SRA;
                    end else begin
                        d.legal = 1'b0;
                    end
                end
                F3_OR:   d.op = ALU_OR;
                default: d.op = ALU_AND;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/multicycle_rv_core_if.sv
// Instruction-memory req/ack fetch interface; the core is the master.
interface multicycle_rv_core_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_REQ;
    logic            IMEM_ACK;
    logic [31:0]     IMEM_DATA;

    modport master (
        output IMEM_ADDR, IMEM_REQ,
        input  IMEM_ACK, IMEM_DATA
    );

    modport slave (
        input  IMEM_ADDR, IMEM_REQ,
        output IMEM_ACK, IMEM_DATA
    );
endinterface

// File: rtl/multicycle_rv_core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, x0 reads as zero.
module mc_regfile
    import multicycle_rv_core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [XLEN-1:0]         wd
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I/RV64I ALU core: FETCH -> DECODE -> EXEC -> WB over a req/ack fetch port.
// Define MULTICYCLE_MUL_EN to add the mul instruction (two-cycle EXEC).
module multicycle_rv_core
    import multicycle_rv_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    multicycle_rv_core_if.master  imem,
    output logic [XLEN-1:0]       OUT,
    output logic                  RETIRE,
    output logic                  ILLEGAL
);

    localparam int RW  = $clog2(NREG);
    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            ill_q, ill_d;
    logic            req_q, req_d;
    logic [31:0]     ir_q, ir_d;
    alu_op_e         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
`ifdef MULTICYCLE_MUL_EN
    logic            mul_wait_q, mul_wait_d;
`endif

    logic [RW-1:0]   ra1, ra2, wa;
    logic [XLEN-1:0] rd1, rd2;
    logic            we;
    dec_t            dec;
    logic            fields_ok;
    logic [XLEN-1:0] imm;

    function automatic logic [XLEN-1:0] alu(input alu_op_e op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = sa >>> sh;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
`ifdef MULTICYCLE_MUL_EN
            ALU_MUL:  r = a * b;
`endif
            default:  r = '0;
        endcase
        return r;
    endfunction

    mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (CLK),
        .rst_n (RST),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (wa),
        .wd    (res_q)
    );

    assign ra1 = ir_q[15 +: RW];
    assign ra2 = ir_q[20 +: RW];
    assign wa  = ir_q[7 +: RW];
    assign dec = decode_ir(ir_q, (XLEN == 64));
    assign imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

    // A register field naming a register this configuration does not have makes the word illegal.
    assign fields_ok = (32'(ir_q[11:7]) < NREG) && (32'(ir_q[19:15]) < NREG) &&
                       (!dec.use_rs2 || (32'(ir_q[24:20]) < NREG));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        ill_d   = ill_q;
        ir_d    = ir_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        we      = 1'b0;
`ifdef MULTICYCLE_MUL_EN
        mul_wait_d = mul_wait_q;
`endif
        case (state_q)
            FETCH: begin
                if (req_q && imem.IMEM_ACK) begin
                    ir_d    = imem.IMEM_DATA;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_d    = dec.op;
                ill_d   = !(dec.legal && fields_ok);
                a_d     = rd1;
                b_d     = dec.use_imm ? imm : rd2;
                state_d = EXEC;
            end
            EXEC: begin
`ifdef MULTICYCLE_MUL_EN
                if ((op_q == ALU_MUL) && !mul_wait_q) begin
                    mul_wait_d = 1'b1;
                end else begin
                    mul_wait_d = 1'b0;
                    res_d      = alu(op_q, a_q, b_q);
                    state_d    = WB;
                end
`else
                res_d   = alu(op_q, a_q, b_q);
                state_d = WB;
`endif
            end
            WB: begin
                if (!ill_q && (ir_q[11:7] != 5'd0)) begin
                    we    = 1'b1;
                    out_d = res_q;
                end
                pc_d    = pc_q + XLEN'(4);
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Registered request: low out of reset, high on every cycle spent in FETCH thereafter.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            out_q   <= '0;
            ill_q   <= 1'b0;
            req_q   <= 1'b0;
`ifdef MULTICYCLE_MUL_EN
            mul_wait_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            ill_q   <= ill_d;
            req_q   <= req_d;
`ifdef MULTICYCLE_MUL_EN
            mul_wait_q <= mul_wait_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        ir_q  <= ir_d;
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign imem.IMEM_ADDR = pc_q;
    assign imem.IMEM_REQ  = req_q;
    assign OUT            = out_q;
    assign RETIRE         = (state_q == WB);
    assign ILLEGAL        = (state_q == WB) && ill_q;

endmodule

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: instruction table with a scoreboard of expected retire results,
// plus a reset-during-EXEC sequence.
module tb_multicycle_rv_core;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] out_w;
    logic retire_w;
    logic illegal_w;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   start_cyc;
    logic [31:0] pc_m;

    typedef struct {
        logic [31:0] instr;
        int          dly;
        logic [31:0] exp_out;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        ill;
        int          lat;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    multicycle_rv_core_if #(.XLEN(32)) imem_if ();

    multicycle_rv_core #(.XLEN(32), .NREG(32), .PC_RESET(32'h0)) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .imem    (imem_if.master),
        .OUT     (out_w),
        .RETIRE  (retire_w),
        .ILLEGAL (illegal_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd);
        return {12'(imm), 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    task automatic add_vec(input logic [31:0] instr, input int dly, input logic [31:0] o,
                           input logic ill, input int lat);
        vec_t v;
        v.instr = instr; v.dly = dly; v.exp_out = o; v.exp_ill = ill; v.exp_lat = lat;
        vq.push_back(v);
    endtask

    // Start at a falling edge; returns at the falling edge two cycles after the accepted ACK.
    task automatic do_fetch(input logic [31:0] w, input int dly);
        int k;
        k = 0;
        while (!imem_if.IMEM_REQ && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_rise", 64'(imem_if.IMEM_REQ), 64'd1);
        start_cyc = cyc;
        check("fetch_addr", 64'(imem_if.IMEM_ADDR), 64'(pc_m));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("req_hold", 64'(imem_if.IMEM_REQ), 64'd1);
            check("addr_hold", 64'(imem_if.IMEM_ADDR), 64'(pc_m));
        end
        imem_if.IMEM_ACK  = 1'b1;
        imem_if.IMEM_DATA = w;
        @(negedge clk);
        check("req_drop", 64'(imem_if.IMEM_REQ), 64'd0);
        imem_if.IMEM_DATA = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_if.IMEM_ACK  = 1'b0;
        imem_if.IMEM_DATA = '0;
    endtask

    task automatic wait_retire();
        exp_t e;
        int   k;
        k = 0;
        while (!retire_w && k < 12) begin
            @(negedge clk);
            k++;
        end
        if (!retire_w) begin
            check("retire_timeout", 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_retire", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("illegal", 64'(illegal_w), 64'(e.ill));
        check("latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
        @(negedge clk);
        check("out", 64'(out_w), 64'(e.out));
        check("retire_pulse", 64'(retire_w), 64'd0);
        pc_m = pc_m + 32'd4;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        imem_if.IMEM_ACK  = 1'b0;
        imem_if.IMEM_DATA = '0;
        pc_m = 32'h0;

        add_vec(enc_i(5, 0, 3'b000, 1),        0, 32'h0000_0005, 1'b0, 4);
        add_vec(enc_i(-3, 0, 3'b000, 2),       0, 32'hFFFF_FFFD, 1'b0, 4);
        add_vec(enc_r(7'h00, 2, 1, 3'b000, 3), 0, 32'h0000_0002, 1'b0, 4);
        add_vec(enc_r(7'h20, 2, 1, 3'b000, 4), 0, 32'h0000_0008, 1'b0, 4);
        add_vec(enc_r(7'h00, 1, 2, 3'b010, 5), 0, 32'h0000_0001, 1'b0, 4);
        add_vec(enc_r(7'h00, 1, 2, 3'b011, 6), 0, 32'h0000_0000, 1'b0, 4);
        add_vec(enc_r(7'h20, 1, 2, 3'b101, 7), 0, 32'hFFFF_FFFF, 1'b0, 4);
        add_vec(enc_i(240, 2, 3'b100, 10),     3, 32'hFFFF_FF0D, 1'b0, 7);
        add_vec(32'hFFFF_FFFF,                 0, 32'hFFFF_FF0D, 1'b1, 4);
        add_vec(enc_r(7'h00, 1, 1, 3'b000, 0), 0, 32'hFFFF_FF0D, 1'b0, 4);
        add_vec(enc_r(7'h00, 0, 0, 3'b000, 8), 0, 32'h0000_0000, 1'b0, 4);
        add_vec(enc_r(7'h00, 1, 1, 3'b001, 11), 0, 32'h0000_00A0, 1'b0, 4);
        add_vec(enc_i(28, 2, 3'b101, 12),      1, 32'h0000_000F, 1'b0, 5);
        add_vec(enc_i(1025, 2, 3'b101, 13),    0, 32'hFFFF_FFFE, 1'b0, 4);
        add_vec(enc_i(-1, 1, 3'b011, 14),      0, 32'h0000_0001, 1'b0, 4);
        add_vec(enc_i(-4, 2, 3'b010, 15),      0, 32'h0000_0000, 1'b0, 4);
        add_vec(enc_i(127, 2, 3'b111, 16),     0, 32'h0000_007D, 1'b0, 4);
        add_vec(enc_r(7'h00, 2, 1, 3'b110, 17), 0, 32'hFFFF_FFFD, 1'b0, 4);
        add_vec(enc_r(7'h00, 2, 1, 3'b111, 18), 0, 32'h0000_0005, 1'b0, 4);
        add_vec(enc_r(7'h00, 2, 1, 3'b100, 19), 0, 32'hFFFF_FFF8, 1'b0, 4);
        add_vec(enc_i(291, 0, 3'b110, 20),     0, 32'h0000_0123, 1'b0, 4);
        add_vec(enc_r(7'h20, 2, 1, 3'b111, 21), 0, 32'h0000_0123, 1'b1, 4);
`ifdef MULTICYCLE_MUL_EN
        add_vec(enc_r(7'h01, 2, 1, 3'b000, 3), 0, 32'hFFFF_FFF1, 1'b0, 5);
`else
        add_vec(enc_r(7'h01, 2, 1, 3'b000, 3), 0, 32'h0000_0123, 1'b1, 4);
`endif
        add_vec(enc_i(-6, 1, 3'b000, 22),      0, 32'hFFFF_FFFF, 1'b0, 4);
        add_vec(enc_i(1, 22, 3'b000, 23),      0, 32'h0000_0000, 1'b0, 4);
        add_vec(enc_i(1025, 1, 3'b001, 24),    0, 32'h0000_0000, 1'b1, 4);
        add_vec(enc_i(85, 0, 3'b000, 24),      0, 32'h0000_0055, 1'b0, 4);

        repeat (3) @(negedge clk);
        check("reset_req", 64'(imem_if.IMEM_REQ), 64'd0);
        check("reset_retire", 64'(retire_w), 64'd0);
        check("reset_illegal", 64'(illegal_w), 64'd0);
        check("reset_out", 64'(out_w), 64'd0);
        check("reset_addr", 64'(imem_if.IMEM_ADDR), 64'h0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            e.out = vq[i].exp_out;
            e.ill = vq[i].exp_ill;
            e.lat = vq[i].exp_lat;
            sb.push_back(e);
            do_fetch(vq[i].instr, vq[i].dly);
            wait_retire();
        end

        // addi x9,x0,7 aborted by reset while in EXEC.
        do_fetch(enc_i(7, 0, 3'b000, 9), 0);
        check("exec_no_retire", 64'(retire_w), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out", 64'(out_w), 64'd0);
        check("abort_req", 64'(imem_if.IMEM_REQ), 64'd0);
        check("abort_retire", 64'(retire_w), 64'd0);
        @(negedge clk);
        check("abort_retire_held", 64'(retire_w), 64'd0);
        rst_n = 1'b1;
        pc_m = 32'h0;

        // addi x26,x9,1 shows x9 was never written.
        e.out = 32'h0000_0001; e.ill = 1'b0; e.lat = 4;
        sb.push_back(e);
        do_fetch(enc_i(1, 9, 3'b000, 26), 0);
        wait_retire();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
